// File: rtl/dcache_if.sv
// +----------------------------------------------------------------------------+
// | dcache_if                                                                  |
// | CPU load/store port and main-memory block port of the data cache.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dcache_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int WORD_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 128
);
  logic [ADDRESS_WIDTH-1:0] i_CpuAddr;
  logic [WORD_WIDTH-1:0]    i_CpuWData;
  logic                     i_CpuRead;
  logic                     i_CpuWrite;
  logic [WORD_WIDTH-1:0]    o_CpuRData;
  logic                     o_Stall;
  logic [ADDRESS_WIDTH-1:0] o_MemReadAddr;
  logic [ADDRESS_WIDTH-1:0] o_MemWriteAddr;
  logic                     o_MemReadEnable;
  logic                     o_MemWriteEnable;
  logic [BLOCK_SIZE-1:0]    o_DataToMem;
  logic [BLOCK_SIZE-1:0]    i_DataFromMem;
  logic                     i_MemReady;

  // Cache controller side: initiator of the memory block protocol.
  modport master (
    input  i_CpuAddr, i_CpuWData, i_CpuRead, i_CpuWrite, i_DataFromMem, i_MemReady,
    output o_CpuRData, o_Stall, o_MemReadAddr, o_MemWriteAddr,
           o_MemReadEnable, o_MemWriteEnable, o_DataToMem
  );

  // Core and memory side.
  modport slave (
    output i_CpuAddr, i_CpuWData, i_CpuRead, i_CpuWrite, i_DataFromMem, i_MemReady,
    input  o_CpuRData, o_Stall, o_MemReadAddr, o_MemWriteAddr,
           o_MemReadEnable, o_MemWriteEnable, o_DataToMem
  );
endinterface

`default_nettype wire

// File: rtl/dcache_controller.sv
// +----------------------------------------------------------------------------+
// | dcache_controller                                                          |
// | Direct-mapped write-back/write-allocate data cache; optional statistics    |
// | counters enabled with macro DCACHE_STATS_EN.                               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module dcache_controller #(
  parameter int BLOCK_SIZE    = 128,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_LINES     = 16,
  parameter int WORD_WIDTH    = 32
) (
  input  wire logic i_clk,
  input  wire logic i_aresetn,
  dcache_if.master  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] o_HitCount,
  output logic [31:0] o_MissCount,
  output logic [31:0] o_WritebackCount
`endif
);

  localparam int c_WORDS   = BLOCK_SIZE / WORD_WIDTH;
  localparam int c_OFF_W   = $clog2(c_WORDS);
  localparam int c_INDEX_W = $clog2(NUM_LINES);
  localparam int c_TAG_W   = ADDRESS_WIDTH - c_OFF_W - c_INDEX_W;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [NUM_LINES-1:0]     r_valid;
  logic [NUM_LINES-1:0]     r_dirty;
  logic [c_TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [BLOCK_SIZE-1:0]    r_data [NUM_LINES];
  logic [c_INDEX_W-1:0]     r_miss_idx;
  logic [c_TAG_W-1:0]       r_miss_tag;
  logic                     r_rd_en;
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_rd_addr;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [BLOCK_SIZE-1:0]    r_to_mem;

  logic [c_OFF_W-1:0]       w_off;
  logic [c_INDEX_W-1:0]     w_idx;
  logic [c_TAG_W-1:0]       w_tag;
  logic                     w_req;
  logic                     w_hit;
  logic [WORD_WIDTH-1:0]    w_word;

  assign w_off  = bus.i_CpuAddr[c_OFF_W-1:0];
  assign w_idx  = bus.i_CpuAddr[c_OFF_W +: c_INDEX_W];
  assign w_tag  = bus.i_CpuAddr[ADDRESS_WIDTH-1 -: c_TAG_W];
  assign w_req  = bus.i_CpuRead | bus.i_CpuWrite;
  assign w_hit  = (r_state == LOOKUP) & w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_word = r_data[w_idx][w_off*WORD_WIDTH +: WORD_WIDTH];

  // On a read+write hit the read port still shows the word before the store.
  assign bus.o_CpuRData       = w_hit ? w_word : '0;
  assign bus.o_Stall          = (r_state != LOOKUP) | (w_req & ~w_hit);
  assign bus.o_MemReadEnable  = r_rd_en;
  assign bus.o_MemWriteEnable = r_wr_en;
  assign bus.o_MemReadAddr    = r_rd_addr;
  assign bus.o_MemWriteAddr   = r_wr_addr;
  assign bus.o_DataToMem      = r_to_mem;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= LOOKUP;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_to_mem   <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        LOOKUP: begin
          if (w_hit) begin
            if (bus.i_CpuWrite) begin
              r_data[w_idx][w_off*WORD_WIDTH +: WORD_WIDTH] <= bus.i_CpuWData;
              r_dirty[w_idx] <= 1'b1;
            end
          end else if (w_req) begin
            r_miss_idx <= w_idx;
            r_miss_tag <= w_tag;
            r_rd_addr  <= {w_tag, w_idx, {c_OFF_W{1'b0}}};
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state   <= WRITEBACK;
              r_wr_en   <= 1'b1;
              r_wr_addr <= {r_tag[w_idx], w_idx, {c_OFF_W{1'b0}}};
              r_to_mem  <= r_data[w_idx];
            end else begin
              r_state <= ALLOCATE;
              r_rd_en <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.i_MemReady) begin
            r_wr_en             <= 1'b0;
            r_dirty[r_miss_idx] <= 1'b0;
            r_rd_en             <= 1'b1;
            r_state             <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.i_MemReady) begin
            r_rd_en             <= 1'b0;
            r_data[r_miss_idx]  <= bus.i_DataFromMem;
            r_tag[r_miss_idx]   <= r_miss_tag;
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
            r_state             <= LOOKUP;
          end
        end
        default: r_state <= LOOKUP;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_HitCount       <= '0;
      o_MissCount      <= '0;
      o_WritebackCount <= '0;
    end else begin
      if (w_hit)
        o_HitCount <= o_HitCount + 32'd1;
      if ((r_state == LOOKUP) && w_req && !w_hit)
        o_MissCount <= o_MissCount + 32'd1;
      if ((r_state == WRITEBACK) && bus.i_MemReady)
        o_WritebackCount <= o_WritebackCount + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// +----------------------------------------------------------------------------+
// | tb_dcache_controller                                                       |
// | Scoreboard bench for dcache_controller with a block main-memory model.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_controller;
  localparam int AW = 10;
  localparam int WW = 32;
  localparam int BS = 128;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  dcache_controller #(
    .BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW), .NUM_LINES(NL), .WORD_WIDTH(WW)
  ) dut (
    .i_clk(clk),
    .i_aresetn(rst_n),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .o_HitCount(hit_cnt),
    .o_MissCount(miss_cnt),
    .o_WritebackCount(wb_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    int          stall;
    bit          chk_rdata;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int          rd_seen, wr_seen, both_seen;
  logic [9:0]  last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;
  int          exp_hits, exp_miss, exp_wb;
  int          n_checks, n_pass;

  // Memory answers each enable with a one-cycle ready pulse half a cycle later.
  always @(negedge clk) begin
    if (bus.o_MemReadEnable && bus.o_MemWriteEnable) both_seen++;
    if (bus.o_MemWriteEnable) begin
      wr_seen++;
      last_wr_addr = bus.o_MemWriteAddr;
      last_wr_data = bus.o_DataToMem;
      for (int k = 0; k < 4; k++) mem[int'(bus.o_MemWriteAddr) + k] = bus.o_DataToMem[k*32 +: 32];
    end
    if (bus.o_MemReadEnable) begin
      rd_seen++;
      last_rd_addr = bus.o_MemReadAddr;
      bus.i_DataFromMem = {mem[int'(bus.o_MemReadAddr) + 3], mem[int'(bus.o_MemReadAddr) + 2],
                           mem[int'(bus.o_MemReadAddr) + 1], mem[int'(bus.o_MemReadAddr)]};
    end
    bus.i_MemReady = bus.o_MemReadEnable | bus.o_MemWriteEnable;
  end

  task automatic do_req(input logic [9:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                        input int exp_stall, input string name);
    exp_t e;
    exp_t got;
    int   stalls = 0;
    bit   done = 0;
    logic [31:0] rdata;
    e.rdata = ref_mem[a];
    e.stall = exp_stall;
    e.chk_rdata = rd;
    e.name = name;
    sb.push_back(e);
    exp_hits++;
    if (exp_stall > 0) exp_miss++;
    if (exp_stall == 3) exp_wb++;
    bus.i_CpuAddr  = a;
    bus.i_CpuWData = wd;
    bus.i_CpuRead  = rd;
    bus.i_CpuWrite = wr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.o_Stall) begin
        done = 1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    rdata = bus.o_CpuRData;
    @(posedge clk);
    #1;
    bus.i_CpuRead  = 1'b0;
    bus.i_CpuWrite = 1'b0;
    if (wr) ref_mem[a] = wd;
    got = sb.pop_front();
    n_checks++;
    if (!done) $display("FAIL %s_timeout: stall still high after %0d cycles, required release", got.name, stalls);
    else n_pass++;
    n_checks++;
    if (stalls !== got.stall) $display("FAIL %s_stall: got %0d cycles, expected %0d", got.name, stalls, got.stall);
    else n_pass++;
    if (got.chk_rdata) begin
      n_checks++;
      if (rdata !== got.rdata) $display("FAIL %s_rdata: got %h, expected %h", got.name, rdata, got.rdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    bus.i_CpuAddr  = '0;
    bus.i_CpuWData = '0;
    bus.i_CpuRead  = 1'b0;
    bus.i_CpuWrite = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.o_MemReadEnable, bus.o_MemWriteEnable} !== 2'b00)
      $display("FAIL reset_en: got %b, expected 00", {bus.o_MemReadEnable, bus.o_MemWriteEnable});
    else n_pass++;
    n_checks++;
    if ({bus.o_MemReadAddr, bus.o_MemWriteAddr} !== 20'h0)
      $display("FAIL reset_addr: got %h/%h, expected 0/0", bus.o_MemReadAddr, bus.o_MemWriteAddr);
    else n_pass++;
    n_checks++;
    if (bus.o_DataToMem !== 128'h0) $display("FAIL reset_data: got %h, expected 0", bus.o_DataToMem);
    else n_pass++;
    n_checks++;
    if (bus.o_Stall !== 1'b0) $display("FAIL reset_idle_stall: got %b, expected 0", bus.o_Stall);
    else n_pass++;
    bus.i_CpuAddr = 10'h045;
    bus.i_CpuRead = 1'b1;
    #1;
    n_checks++;
    if (bus.o_Stall !== 1'b1) $display("FAIL reset_miss_stall: got %b, expected 1", bus.o_Stall);
    else n_pass++;
    n_checks++;
    if (bus.o_CpuRData !== 32'h0) $display("FAIL reset_miss_rdata: got %h, expected 0", bus.o_CpuRData);
    else n_pass++;
    bus.i_CpuRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_load();
    int rd0 = rd_seen;
    int wr0 = wr_seen;
    do_req(10'h045, 32'h0, 1, 0, 2, "cold_load");
    n_checks++;
    if (last_rd_addr !== 10'h044) $display("FAIL cold_rd_addr: got %h, expected 044", last_rd_addr);
    else n_pass++;
    n_checks++;
    if (rd_seen - rd0 !== 1) $display("FAIL cold_rd_cycles: got %0d, expected 1", rd_seen - rd0);
    else n_pass++;
    n_checks++;
    if (wr_seen !== wr0) $display("FAIL cold_no_write: got %0d write cycles, expected 0", wr_seen - wr0);
    else n_pass++;
  endtask

  task automatic test_store_hit();
    do_req(10'h046, 32'hDEADBEEF, 0, 1, 0, "store_hit");
    do_req(10'h046, 32'h0, 1, 0, 0, "load_after_store");
  endtask

  task automatic test_dirty_evict();
    do_req(10'h086, 32'h0, 1, 0, 3, "dirty_evict");
    n_checks++;
    if (last_wr_addr !== 10'h044) $display("FAIL evict_wr_addr: got %h, expected 044", last_wr_addr);
    else n_pass++;
    n_checks++;
    if (last_wr_data !== {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0})
      $display("FAIL evict_wr_data: got %h, expected %h", last_wr_data, {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0});
    else n_pass++;
    n_checks++;
    if (last_rd_addr !== 10'h084) $display("FAIL evict_rd_addr: got %h, expected 084", last_rd_addr);
    else n_pass++;
  endtask

  task automatic test_store_miss();
    do_req(10'h3FF, 32'h55, 0, 1, 2, "store_miss");
    n_checks++;
    if (last_rd_addr !== 10'h3FC) $display("FAIL store_miss_rd_addr: got %h, expected 3FC", last_rd_addr);
    else n_pass++;
    do_req(10'h3FF, 32'h0, 1, 0, 0, "store_miss_merged");
    do_req(10'h3FC, 32'h0, 1, 0, 0, "store_miss_refill_word0");
    // The merged store left the line dirty, so a conflicting load must evict it.
    do_req(10'h03F, 32'h0, 1, 0, 3, "store_miss_evict");
    n_checks++;
    if (last_wr_addr !== 10'h3FC) $display("FAIL store_miss_wb_addr: got %h, expected 3FC", last_wr_addr);
    else n_pass++;
    n_checks++;
    if (last_wr_data[127:96] !== 32'h55) $display("FAIL store_miss_wb_word3: got %h, expected 00000055", last_wr_data[127:96]);
    else n_pass++;
  endtask

  task automatic test_read_write_same();
    do_req(10'h084, 32'h12345678, 1, 1, 0, "rw_same_cycle");
    do_req(10'h084, 32'h0, 1, 0, 0, "rw_after");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bus.i_CpuAddr = 10'h200;
    bus.i_CpuRead = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_MemReadEnable) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL midreset_no_read_en: got 0, expected 1");
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_MemReadEnable, bus.o_MemWriteEnable} !== 2'b00)
      $display("FAIL midreset_en_drop: got %b, expected 00", {bus.o_MemReadEnable, bus.o_MemWriteEnable});
    else n_pass++;
    n_checks++;
    if (bus.o_Stall !== 1'b1) $display("FAIL midreset_stall: got %b, expected 1", bus.o_Stall);
    else n_pass++;
    bus.i_CpuRead = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    exp_wb   = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(10'h200, 32'h0, 1, 0, 2, "midreset_repeat");
    do_req(10'h084, 32'h0, 1, 0, 2, "midreset_line_lost");
  endtask

  task automatic test_one_enable();
    n_checks++;
    if (both_seen !== 0) $display("FAIL one_enable: got %0d overlap cycles, expected 0", both_seen);
    else n_pass++;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    n_checks++;
    if (hit_cnt !== exp_hits) $display("FAIL stats_hit: got %0d, expected %0d", hit_cnt, exp_hits);
    else n_pass++;
    n_checks++;
    if (miss_cnt !== exp_miss) $display("FAIL stats_miss: got %0d, expected %0d", miss_cnt, exp_miss);
    else n_pass++;
    n_checks++;
    if (wb_cnt !== exp_wb) $display("FAIL stats_wb: got %0d, expected %0d", wb_cnt, exp_wb);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[10'h044] = 32'hA0;
    mem[10'h045] = 32'hA1;
    mem[10'h046] = 32'hA2;
    mem[10'h047] = 32'hA3;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_read_write_same();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_one_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

`default_nettype wire
